alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream issue stage for the 4-bit combinational ALU. It accepts operation commands {a, b, opcode} over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto registered ALU inputs, captures the ALU's {y, x} result one cycle later, and canonicalises it. It then presents the result downstream over a valid/ready handshake.

Parameters:
DEPTH, 4, command FIFO depth; power of 2, minimum 2.
CW, $clog2(DEPTH+1), width of the fifo_count output.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  command present.
in_ready  output  1  FIFO can accept a command.
in_a  input  4  operand a.
in_b  input  4  operand b.
in_op  input  4  ALU opcode.
alu_a  output  4  registered operand a to the ALU.
alu_b  output  4  registered operand b to the ALU.
alu_opcode  output  4  registered opcode to the ALU.
alu_x  input  4  ALU result x (combinational from alu_* outputs).
alu_y  input  4  ALU result y.
out_valid  output  1  result held.
out_ready  input  1  downstream accepts the result.
out_x  output  4  canonical result x.
out_y  output  4  canonical result y.
out_op  output  4  opcode that produced the result.
fifo_count  output  CW  FIFO occupancy.
busy  output  1  high when state is not IDLE or the FIFO is not empty.

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE, FIFO empty, fifo_count 0.
  - alu_a, alu_b, alu_opcode, out_x, out_y, out_op all 0; out_valid 0.
  - In-flight and buffered commands are discarded; no partial result is emitted.
- in_ready = (fifo_count < DEPTH). It depends only on occupancy, not on a same-cycle pop.
- Push occurs when in_valid && in_ready. Push and pop in the same cycle leave the count unchanged. Push when full is impossible by construction.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_opcode and go to EXEC.
  - EXEC (exactly one cycle; the ALU settles): capture the canonicalised alu_x/alu_y into out_x/out_y, alu_opcode into out_op, set out_valid=1, go to DONE.
  - DONE: hold outputs stable while out_valid && !out_ready. On out_ready:
    - if the FIFO is non-empty, pop the next head into the alu_* registers, clear out_valid, and go to EXEC on the same edge;
    - otherwise clear out_valid and go to IDLE.
- Latency: command pushed at edge N with the FIFO empty and state IDLE → popped at N+1 → out_valid at N+2.
- Throughput: 1 op per 2 cycles.
- alu_* registers hold their last values in IDLE and DONE.
- Canonicalisation (combinational on capture):
  - Single-bit opcodes 0000, 0001, 0010, 0110, 0111, 1000, 1001: out_x = {3'b0, alu_x[0]}, out_y = 0.
  - Opcodes 0011, 0100, 0101, 1011, 1111: out_x = alu_x, out_y = 0.
  - Opcode 1010: out_x = alu_x, out_y = {3'b0, alu_y[0]}.
  - Opcodes 1100, 1101, 1110: out_x = alu_x, out_y = alu_y.
- No X may propagate to out_x/out_y for any opcode.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_OR_RED … OP_NOT);
  - result-class enum {SINGLE_BIT, X_ONLY, X_CARRY, X_Y};
  - function op_class(opcode).
- FIFO as a separate sub-module, alu_cmd_fifo:
  - DEPTH × 12-bit synchronous FIFO, asynchronous reset;
  - outputs count, full, empty;
  - head data visible without a read latency.
- Sequencer FSM and canonicalisation stay in alu_op_sequencer.

Test Plan:
- ADD: push a=9, b=8, op=1010 with out_ready=1 → out_valid two cycles after push; out_x=0001, out_y=0001, out_op=1010.
- MUL: push a=F, b=F, op=1100 → out_y=1110, out_x=0001. SHL: push a=3, b=2, op=1110 → out_y=0000, out_x=1100.
- Canonicalisation: push AND-reduce a=F op=0001, with a stub ALU driving alu_x=1111 and alu_y=1111 → out_x=0001, out_y=0000.
- Backpressure: out_ready=0, push 6 back-to-back commands → first goes to EXEC/DONE, next 4 fill the FIFO; fifo_count=4, in_ready=0, and the 6th is stalled. Raise out_ready → all 6 results emerge in order at one per 2 cycles; out_x/out_y stay stable while stalled.
- Simultaneous push/pop: FIFO at 3, push while DONE pops → fifo_count stays 3.
- Reset mid-EXEC with 2 queued commands → out_valid=0, fifo_count=0, all outputs 0. A new command after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, result classes,
// command layout, sequencer states and the opcode classifier.
package alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_OR_RED  = 4'b0000;
  localparam logic [3:0] OP_AND_RED = 4'b0001;
  localparam logic [3:0] OP_XOR_RED = 4'b0010;
  localparam logic [3:0] OP_AND     = 4'b0011;
  localparam logic [3:0] OP_OR      = 4'b0100;
  localparam logic [3:0] OP_XOR     = 4'b0101;
  localparam logic [3:0] OP_EQ      = 4'b0110;
  localparam logic [3:0] OP_LT      = 4'b0111;
  localparam logic [3:0] OP_GT      = 4'b1000;
  localparam logic [3:0] OP_PAR     = 4'b1001;
  localparam logic [3:0] OP_ADD     = 4'b1010;
  localparam logic [3:0] OP_SUB     = 4'b1011;
  localparam logic [3:0] OP_MUL     = 4'b1100;
  localparam logic [3:0] OP_DIV     = 4'b1101;
  localparam logic [3:0] OP_SHL     = 4'b1110;
  localparam logic [3:0] OP_NOT     = 4'b1111;

  localparam int CMD_W = 12;

  // Which parts of the raw ALU result carry meaning for an opcode
  typedef enum logic [1:0] {
    SINGLE_BIT = 2'd0,
    X_ONLY     = 2'd1,
    X_CARRY    = 2'd2,
    X_Y        = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } alu_cmd_t;

  // Map an opcode to its result class; unknown codes fall back to the
  // narrowest class so stray result bits are masked off.
  function automatic op_class_t op_class(input logic [3:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_OR_RED, OP_AND_RED, OP_XOR_RED,
      OP_EQ, OP_LT, OP_GT, OP_PAR:          cls = SINGLE_BIT;
      OP_AND, OP_OR, OP_XOR, OP_SUB, OP_NOT: cls = X_ONLY;
      OP_ADD:                               cls = X_CARRY;
      OP_MUL, OP_DIV, OP_SHL:               cls = X_Y;
      default:                              cls = SINGLE_BIT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of 12 bits, head visible combinationally,
// occupancy counter with full/empty flags.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents cleared on reset so the head is never X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {CMD_W{1'b0}};
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: buffers commands, drives one at a time
// onto registered ALU inputs, captures and canonicalises the result and
// hands it downstream over valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  input  logic [3:0]    in_op,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_opcode,
  input  logic [3:0]    alu_x,
  input  logic [3:0]    alu_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_x,
  output logic [3:0]    out_y,
  output logic [3:0]    out_op,
  output logic [CW-1:0] fifo_count,
  output logic          busy
);

  seq_state_t state;
  seq_state_t next_state;

  alu_cmd_t   in_cmd;
  alu_cmd_t   head_cmd;
  logic [CMD_W-1:0] head_bits;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       capture;
  logic       clr_valid;
  logic [3:0] canon_x;
  logic [3:0] canon_y;

  assign in_cmd   = '{a: in_a, b: in_b, op: in_op};
  assign head_cmd = alu_cmd_t'(head_bits);
  // Acceptance looks only at occupancy, never at a same-cycle pop
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_cmd),
    .pop       (pop),
    .head      (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = EXEC;
        end else begin
          next_state = IDLE;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          clr_valid = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = EXEC;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Keep only the result bits that are meaningful for the executing opcode
  always_comb begin
    canon_x = 4'b0000;
    canon_y = 4'b0000;
    case (op_class(alu_opcode))
      SINGLE_BIT: begin
        canon_x = {3'b000, alu_x[0]};
        canon_y = 4'b0000;
      end
      X_ONLY: begin
        canon_x = alu_x;
        canon_y = 4'b0000;
      end
      X_CARRY: begin
        canon_x = alu_x;
        canon_y = {3'b000, alu_y[0]};
      end
      X_Y: begin
        canon_x = alu_x;
        canon_y = alu_y;
      end
      default: begin
        canon_x = 4'b0000;
        canon_y = 4'b0000;
      end
    endcase
  end

  // ALU operand registers: loaded on pop, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= 4'b0000;
      alu_b      <= 4'b0000;
      alu_opcode <= 4'b0000;
    end else if (pop) begin
      alu_a      <= head_cmd.a;
      alu_b      <= head_cmd.b;
      alu_opcode <= head_cmd.op;
    end
  end

  // Result registers and downstream valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_x     <= 4'b0000;
      out_y     <= 4'b0000;
      out_op    <= 4'b0000;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_x     <= canon_x;
      out_y     <= canon_y;
      out_op    <= alu_opcode;
      out_valid <= 1'b1;
    end else if (clr_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a small
// behavioural ALU (or an all-ones stub) on the ALU side.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b, in_op;
  logic [3:0] alu_a, alu_b, alu_opcode;
  logic [3:0] alu_x, alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x, out_y, out_op;
  logic [2:0] fifo_count;
  logic       busy;
  logic       stub;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Expected-result table for the queued sequences
  logic [3:0] v_a  [11] = '{4'h1, 4'h5, 4'hC, 4'h3, 4'hF, 4'h5, 4'h5, 4'h7, 4'h7, 4'h4, 4'h8};
  logic [3:0] v_b  [11] = '{4'h2, 4'h3, 4'hA, 4'h5, 4'h1, 4'h1, 4'hA, 4'h2, 4'h2, 4'h4, 4'h8};
  logic [3:0] v_op [11] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hA, 4'hE, 4'h4, 4'hB, 4'hD, 4'hC, 4'hA};
  logic [3:0] v_x  [11] = '{4'h3, 4'h6, 4'h8, 4'hF, 4'h0, 4'hA, 4'hF, 4'h5, 4'h3, 4'h0, 4'h0};
  logic [3:0] v_y  [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_op     (out_op),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  // Behavioural ALU; unused result bits are driven to ones to expose masking
  always_comb begin
    logic [7:0] wide;
    wide  = 8'h00;
    alu_x = 4'hF;
    alu_y = 4'hF;
    if (!stub) begin
      case (alu_opcode)
        4'b0011: alu_x = alu_a & alu_b;
        4'b0100: alu_x = alu_a | alu_b;
        4'b0101: alu_x = alu_a ^ alu_b;
        4'b1010: begin
          wide  = {4'h0, alu_a} + {4'h0, alu_b};
          alu_x = wide[3:0];
          alu_y = wide[7:4];
        end
        4'b1011: alu_x = alu_a - alu_b;
        4'b1100: begin
          wide  = {4'h0, alu_a} * {4'h0, alu_b};
          alu_x = wide[3:0];
          alu_y = wide[7:4];
        end
        4'b1101: begin
          if (alu_b != 4'h0) begin
            alu_x = alu_a / alu_b;
            alu_y = alu_a % alu_b;
          end
        end
        4'b1110: begin
          wide  = {4'h0, alu_a} << alu_b;
          alu_x = wide[3:0];
          alu_y = wide[7:4];
        end
        default: begin
          alu_x = 4'hF;
          alu_y = 4'hF;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and return one cycle after it is accepted
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    for (int i = 0; i < 60 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a result and compare it
  task automatic expect_result(input string tag, input logic [3:0] x, input logic [3:0] y,
                               input logic [3:0] op);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_x"}, 32'(out_x), 32'(x));
    check({tag, "_y"}, 32'(out_y), 32'(y));
    check({tag, "_op"}, 32'(out_op), 32'(op));
    tick();
  endtask

  // Drain n results (out_ready held high) against table entries base..base+n-1
  task automatic collect(input int n, input int base, input string tag);
    int got;
    int last;
    got  = 0;
    last = 0;
    for (int i = 0; i < 80 && got < n; i++) begin
      if (out_valid) begin
        check({tag, "_x"}, 32'(out_x), 32'(v_x[base + got]));
        check({tag, "_y"}, 32'(out_y), 32'(v_y[base + got]));
        check({tag, "_op"}, 32'(out_op), 32'(v_op[base + got]));
        if (got > 0) check({tag, "_spacing"}, 32'(cycle - last), 32'd2);
        last = cycle;
        got++;
      end
      tick();
    end
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    in_op     = 4'h0;
    out_ready = 1'b1;
    stub      = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_op", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    tick();

    // ADD 9+8 with latency checks
    push(4'h9, 4'h8, 4'hA);
    check("add_cnt_n", 32'(fifo_count), 32'd1);
    check("add_valid_n", 32'(out_valid), 32'd0);
    tick();
    check("add_valid_n1", 32'(out_valid), 32'd0);
    check("add_alu_a", 32'(alu_a), 32'd9);
    check("add_alu_op", 32'(alu_opcode), 32'hA);
    tick();
    check("add_valid_n2", 32'(out_valid), 32'd1);
    check("add_x", 32'(out_x), 32'h1);
    check("add_y", 32'(out_y), 32'h1);
    check("add_op", 32'(out_op), 32'hA);
    tick();
    check("add_valid_after", 32'(out_valid), 32'd0);
    check("add_busy_after", 32'(busy), 32'd0);

    push(4'hF, 4'hF, 4'hC);
    expect_result("mul", 4'h1, 4'hE, 4'hC);
    push(4'h3, 4'h2, 4'hE);
    expect_result("shl", 4'hC, 4'h0, 4'hE);

    // Stub ALU driving all ones
    stub = 1'b1;
    push(4'hF, 4'h0, 4'h1);
    expect_result("canon_and_red", 4'h1, 4'h0, 4'h1);
    push(4'h1, 4'h1, 4'hA);
    expect_result("canon_add", 4'hF, 4'h1, 4'hA);
    stub = 1'b0;
    tick();

    // Backpressure with six commands
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(v_a[i], v_b[i], v_op[i]);
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_a     = v_a[5];
    in_b     = v_b[5];
    in_op    = v_op[5];
    tick();
    tick();
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_stall_count", 32'(fifo_count), 32'd4);
    check("bp_stall_x", 32'(out_x), 32'h3);
    check("bp_stall_y", 32'(out_y), 32'h0);
    check("bp_stall_op", 32'(out_op), 32'hA);
    out_ready = 1'b1;
    fork
      push(v_a[5], v_b[5], v_op[5]);
      collect(6, 0, "bp");
    join
    check("bp_idle", 32'(busy), 32'd0);

    // Simultaneous push and pop at occupancy 3
    out_ready = 1'b0;
    for (int i = 6; i < 10; i++) push(v_a[i], v_b[i], v_op[i]);
    check("pp_count_pre", 32'(fifo_count), 32'd3);
    check("pp_valid_pre", 32'(out_valid), 32'd1);
    in_valid  = 1'b1;
    in_a      = v_a[10];
    in_b      = v_b[10];
    in_op     = v_op[10];
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_count_post", 32'(fifo_count), 32'd3);
    check("pp_valid_post", 32'(out_valid), 32'd0);
    // First of the five has just been taken; check its values via the table below
    collect(4, 7, "pp");

    // Reset in EXEC with two commands queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(v_a[i], v_b[i], v_op[i]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_count", 32'(fifo_count), 32'd2);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_alu_op", 32'(alu_opcode), 32'h5);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_count", 32'(fifo_count), 32'd0);
    check("mrst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    check("mrst_out", 32'({out_x, out_y, out_op}), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    push(4'h9, 4'h8, 4'hA);
    expect_result("post_rst_add", 4'h1, 4'h1, 4'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
